// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle.
// Core side: req/resp handshakes. Memory side: addr/rw/wdata/counter/rdata.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_base;
    logic [63:0] req_offset;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_addr;
    logic        mem_rw;
    logic [63:0] mem_wdata;
    logic [2:0]  mem_counter;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3,
        input  req_base, req_offset, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid,
        output resp_rdata, resp_fault,
        output mem_addr, mem_rw,
        output mem_wdata, mem_counter
    );

    modport master (
        output req_valid, req_store, req_funct3,
        output req_base, req_offset, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid,
        input  resp_rdata, resp_fault,
        input  mem_addr, mem_rw,
        input  mem_wdata, mem_counter
    );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store unit: one request at a time, RMW for sub-dword stores.
// Ports: clk, rst_n (async, active-low), bus (load_store_unit_if.slave).
module load_store_unit #(
    parameter int MEM_WORDS   = 32,
    parameter int WRITE_PHASE = 3
) (
    input logic         clk,
    input logic         rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, READ, WAIT, WRITE, RESP
    } state_t;

    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd8;
    localparam logic [2:0]  PHASE     = 3'(WRITE_PHASE);

    state_t      state_q, state_d;
    logic        store_q;
    logic [2:0]  f3_q;
    logic [63:0] ea_q;
    logic [63:0] wdata_q;
    logic [63:0] rdata_q;
    logic        fault_q;

    logic [63:0] ea;
    logic        misalign;
    logic        fault;

    assign ea = bus.req_base + bus.req_offset;

    always_comb begin
        misalign = 1'b0;
        unique case (bus.req_funct3[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = ea[0];
            2'b10:   misalign = |ea[1:0];
            default: misalign = |ea[2:0];
        endcase
    end

    assign fault = (bus.req_funct3 == 3'b111)
                 | (bus.req_store & bus.req_funct3[2])
                 | misalign
                 | (ea >= MEM_BYTES);

    logic [2:0]  lane;
    logic [63:0] shifted;
    logic [63:0] ld_val;
    logic [7:0]  size_mask;
    logic [7:0]  byte_en;
    logic [63:0] lane_data;
    logic [63:0] merged;

    assign lane      = ea_q[2:0];
    assign shifted   = bus.mem_rdata >> {lane, 3'b000};
    assign lane_data = wdata_q << {lane, 3'b000};

    always_comb begin
        ld_val = '0;
        unique case (f3_q)
            3'b000:  ld_val = {{56{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_val = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  ld_val = {{32{shifted[31]}}, shifted[31:0]};
            3'b011:  ld_val = shifted;
            3'b100:  ld_val = {56'd0, shifted[7:0]};
            3'b101:  ld_val = {48'd0, shifted[15:0]};
            3'b110:  ld_val = {32'd0, shifted[31:0]};
            default: ld_val = '0;
        endcase
    end

    always_comb begin
        size_mask = 8'h00;
        unique case (f3_q[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0f;
            default: size_mask = 8'hff;
        endcase
        byte_en = size_mask << lane;
        merged  = bus.mem_rdata;
        for (int i = 0; i < 8; i++) begin
            if (byte_en[i]) merged[i*8 +: 8] = lane_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = '0;
        bus.resp_fault  = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_rw      = 1'b0;
        bus.mem_wdata   = '0;
        bus.mem_counter = 3'd0;
        case (state_q)
            IDLE: begin
                // rst_n gate keeps ready low while reset is held.
                bus.req_ready = rst_n;
                if (bus.req_valid) begin
                    if (fault)
                        state_d = RESP;
                    else if (bus.req_store && bus.req_funct3 == 3'b011)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                bus.mem_addr = ea_q;
                state_d      = WAIT;
            end
            WAIT: begin
                bus.mem_addr = ea_q;
                state_d      = store_q ? WRITE : RESP;
            end
            WRITE: begin
                bus.mem_addr    = ea_q;
                bus.mem_rw      = 1'b1;
                bus.mem_wdata   = wdata_q;
                bus.mem_counter = PHASE;
                state_d         = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_fault = fault_q;
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // wdata_q holds raw store data for SD and the merged dword after WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q <= 1'b0;
            f3_q    <= 3'd0;
            ea_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        store_q <= bus.req_store;
                        f3_q    <= bus.req_funct3;
                        ea_q    <= ea;
                        wdata_q <= bus.req_wdata;
                        rdata_q <= '0;
                        fault_q <= fault;
                    end
                end
                WAIT: begin
                    if (store_q) wdata_q <= merged;
                    else         rdata_q <= ld_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit.
// Models a 32-dword memory with one-cycle read latency.
module tb_load_store_unit;
    logic clk;
    logic rst_n;

    load_store_unit_if bus();

    load_store_unit #(
        .MEM_WORDS(32),
        .WRITE_PHASE(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mem[32];
    logic [63:0] shadow[32];
    logic [63:0] rd;
    logic        pl_we;
    logic [4:0]  pl_idx;
    logic [63:0] pl_val;
    int          n_checks;
    int          n_fail;
    int          wr_cycles;
    int          busy_cycles;
    int          bad_phase;
    logic [63:0] w_addr;
    logic [63:0] w_data;
    logic [2:0]  w_cnt;

    assign bus.mem_rdata = rd;

    always @(posedge clk) begin
        if (pl_we)
            mem[pl_idx] <= pl_val;
        else if (bus.mem_rw && bus.mem_counter == 3'd3)
            mem[bus.mem_addr[7:3]] <= bus.mem_wdata;
        if (!bus.mem_rw) rd <= mem[bus.mem_addr[7:3]];
    end

    always @(negedge clk) begin
        if (bus.mem_rw) begin
            wr_cycles = wr_cycles + 1;
            w_addr    = bus.mem_addr;
            w_data    = bus.mem_wdata;
            w_cnt     = bus.mem_counter;
        end
        if (bus.mem_rw || bus.mem_addr != 64'd0)
            busy_cycles = busy_cycles + 1;
        if (bus.mem_counter != 3'd0 && bus.mem_counter != 3'd3)
            bad_phase = bad_phase + 1;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] d,
                                             input int lane,
                                             input logic [2:0] f3);
        int nb = 1 << f3[1:0];
        logic [63:0] v = '0;
        for (int i = 0; i < nb; i++)
            v[i*8 +: 8] = d[(lane+i)*8 +: 8];
        if (!f3[2] && v[nb*8-1])
            for (int i = nb*8; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] ref_store(input logic [63:0] d,
                                              input int lane,
                                              input logic [2:0] f3,
                                              input logic [63:0] w);
        int nb = 1 << f3[1:0];
        logic [63:0] v = d;
        for (int i = 0; i < nb; i++)
            v[(lane+i)*8 +: 8] = w[i*8 +: 8];
        return v;
    endfunction

    task automatic send(input logic st, input logic [2:0] f3,
                        input logic [63:0] base, input logic [63:0] off,
                        input logic [63:0] wd);
        logic [63:0] ea;
        int nb;
        logic flt;
        exp_t e;
        ea  = base + off;
        nb  = 1 << f3[1:0];
        flt = (f3 == 3'b111) || (st && f3[2]) ||
              ((ea & 64'(nb - 1)) != 64'd0) || (ea >= 64'd256);
        e.fault = flt;
        e.lat   = flt ? 1 : (!st ? 3 : (f3[1:0] == 2'b11 ? 2 : 4));
        e.rdata = '0;
        if (!flt && !st)
            e.rdata = ref_load(shadow[ea[7:3]], int'(ea[2:0]), f3);
        if (!flt && st)
            shadow[ea[7:3]] = ref_store(shadow[ea[7:3]],
                                        int'(ea[2:0]), f3, wd);
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_wdata  = wd;
        check("req_ready_before", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int lat = 1;
        @(negedge clk);
        while (!bus.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check("resp_latency", 64'(lat), 64'(e.lat));
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_fault", 64'(bus.resp_fault), 64'(e.fault));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.resp_valid), 64'd1);
            check("hold_req_ready", 64'(bus.req_ready), 64'd0);
            check("hold_rdata", bus.resp_rdata, e.rdata);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("resp_done", 64'(bus.resp_valid), 64'd0);
        check("back_idle", 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        int b0;
        int found;
        logic st;
        logic [2:0] f3;
        int idx;
        int lane;
        int nb;
        logic [63:0] ea;
        logic [63:0] base;
        n_checks = 0;
        n_fail = 0;
        wr_cycles = 0;
        busy_cycles = 0;
        bad_phase = 0;
        rst_n = 1'b0;
        pl_we = 1'b0;
        pl_idx = '0;
        pl_val = '0;
        bus.req_valid = 1'b0;
        bus.req_store = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_base = '0;
        bus.req_offset = '0;
        bus.req_wdata = '0;
        bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_resp_fault", 64'(bus.resp_fault), 64'd0);
        check("rst_mem_addr", bus.mem_addr, 64'd0);
        check("rst_mem_rw", 64'(bus.mem_rw), 64'd0);
        check("rst_mem_wdata", bus.mem_wdata, 64'd0);
        check("rst_mem_counter", 64'(bus.mem_counter), 64'd0);

        for (int i = 0; i < 32; i++)
            shadow[i] = {$urandom, $urandom};
        shadow[1] = 64'h11223344_55667788;
        shadow[2] = 64'h00000000_0000ff80;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            pl_we  = 1'b1;
            pl_idx = 5'(i);
            pl_val = shadow[i];
        end
        @(negedge clk);
        pl_we = 1'b0;
        rst_n = 1'b1;
        #1 check("post_rst_ready", 64'(bus.req_ready), 64'd1);

        send(1'b0, 3'b000, 64'h8, 64'h8, 64'd0);
        collect(0);
        send(1'b0, 3'b101, 64'h10, 64'h0, 64'd0);
        collect(0);

        b0 = wr_cycles;
        send(1'b1, 3'b000, 64'h8, 64'h3, 64'hab);
        collect(0);
        check("sb_write_cycles", 64'(wr_cycles - b0), 64'd1);
        check("sb_addr", w_addr, 64'h0b);
        check("sb_wdata", w_data, 64'h11223344_ab667788);
        check("sb_counter", 64'(w_cnt), 64'd3);
        check("sb_mem", mem[1], 64'h11223344_ab667788);

        b0 = busy_cycles;
        send(1'b0, 3'b010, 64'h0, 64'h6, 64'd0);
        collect(0);
        send(1'b1, 3'b011, 64'h100, 64'h0, 64'h5a5a);
        collect(0);
        send(1'b0, 3'b111, 64'h10, 64'h0, 64'd0);
        collect(0);
        check("fault_no_mem", 64'(busy_cycles - b0), 64'd0);

        send(1'b1, 3'b011, 64'h10, 64'h8, 64'hdeadbeef_cafef00d);
        collect(5);
        check("sd_mem", mem[3], 64'hdeadbeef_cafef00d);
        send(1'b0, 3'b011, 64'h20, -64'sd8, 64'd0);
        collect(0);

        for (int n = 0; n < 40; n++) begin
            st   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            idx  = int'($urandom_range(0, 33));
            lane = int'($urandom_range(0, 7));
            nb   = 1 << f3[1:0];
            if ($urandom_range(0, 3) != 0) lane = lane & ~(nb - 1);
            ea   = 64'(idx * 8 + lane);
            base = {$urandom, $urandom};
            send(st, f3, base, ea - base, {$urandom, $urandom});
            collect(0);
        end
        for (int i = 0; i < 32; i++)
            check("mem_final", mem[i], shadow[i]);
        check("phase_legal", 64'(bad_phase), 64'd0);

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_base   = 64'h20;
        bus.req_offset = 64'h1;
        bus.req_wdata  = 64'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (bus.mem_rw) found = 1;
        end
        check("saw_write", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_counter", 64'(bus.mem_counter), 64'd0);
        check("rstw_rw", 64'(bus.mem_rw), 64'd0);
        check("rstw_addr", bus.mem_addr, 64'd0);
        check("rstw_req_ready", 64'(bus.req_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rstw_ready", 64'(bus.req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstw_no_resp", 64'(bus.resp_valid), 64'd0);
        end
        check("rstw_mem", mem[4], shadow[4]);

        send(1'b0, 3'b011, 64'h20, 64'h0, 64'd0);
        collect(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 32, number of 64-bit doublewords in the data memory.
REQ-002 Parameter WRITE_PHASE, default 3, mem_counter value that commits a memory write.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_store  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RISC-V funct3 (size/sign).
REQ-009 req_base  input  64  base register value.
REQ-010 req_offset  input  64  sign-extended immediate.
REQ-011 req_wdata  input  64  store data (low bytes used).
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  core accepts response.
REQ-014 resp_rdata  output  64  extended load result; 0 for stores and faults.
REQ-015 resp_fault  output  1  misaligned, out-of-range or illegal funct3.
REQ-016 mem_addr  output  64  byte address to data memory.
REQ-017 mem_rw  output  1  0 = read, 1 = write.
REQ-018 mem_wdata  output  64  doubleword to write.
REQ-019 mem_counter  output  3  write-commit phase to data memory.
REQ-020 mem_rdata  input  64  memory read data, valid the cycle after the address is presented with mem_rw=0.

Function
REQ-021 FSM states IDLE, READ, WAIT, WRITE, RESP.
REQ-022 IDLE: req_ready=1; on req_valid latch fields, ea = req_base+req_offset (mod 2^64).
REQ-023 Fault if funct3=111, store with funct3[2]=1, ea not size-aligned (H: ea[0], W: ea[1:0], D: ea[2:0] nonzero), or ea >= 8*MEM_WORDS; faulting request goes IDLE->RESP with no memory access.
REQ-024 Non-faulting SD: IDLE->WRITE; all other accesses: IDLE->READ.
REQ-025 READ: mem_addr=ea, mem_rw=0, mem_counter=0, one cycle, ->WAIT.
REQ-026 WAIT: sample mem_rdata; lane = ea[2:0], little-endian.
REQ-027 Load in WAIT: extract byte/half/word/double at lane; LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend; ->RESP.
REQ-028 Sub-doubleword store in WAIT: merged = mem_rdata with selected bytes replaced by low bytes of req_wdata; ->WRITE.
REQ-029 WRITE: mem_addr=ea, mem_rw=1, mem_counter=WRITE_PHASE, mem_wdata=merged (SD: req_wdata), one cycle, ->RESP.
REQ-030 Outside WRITE: mem_rw=0, mem_counter=0, mem_wdata=0; mem_counter never drives any value other than 0 or WRITE_PHASE.
REQ-031 RESP: resp_valid=1, held with stable resp_rdata/resp_fault until resp_ready; on resp_ready ->IDLE next cycle.
REQ-032 req_ready=0 in all states except IDLE; no request accepted while resp_valid=1.
REQ-033 Latency from accept edge to resp_valid: load 3 cycles, sub-doubleword store 4, SD 2, fault 1.
REQ-034 mem_addr holds ea from READ through WRITE; 0 in IDLE.

Reset
REQ-035 rst_n low immediately forces IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_fault=0, mem_addr=0, mem_rw=0, mem_wdata=0, mem_counter=0.
REQ-036 Reset asserted during WRITE suppresses the write (mem_counter=0 before the next edge); in-flight request discarded, no response.
REQ-037 First cycle after rst_n rises: IDLE, req_ready=1.

Verification
REQ-038 Memory dword 2 = 0x00000000_0000FF80; LB ea=0x10 -> resp_rdata=0xFFFFFFFF_FFFFFF80, fault=0, resp_valid 3 cycles after accept.
REQ-039 Same memory, LHU ea=0x10 -> resp_rdata=0x00000000_0000FF80.
REQ-040 Dword 1 = 0x11223344_55667788; SB base=0x8 offset=3 wdata=0xAB -> one write cycle with mem_counter=3, mem_wdata=0x11223344_AB667788, addr 0x0B.
REQ-041 LW ea=0x6 -> resp_fault=1, rdata=0, no READ/WRITE cycle; SD ea=0x100 (MEM_WORDS=32) -> fault; funct3=111 -> fault.
REQ-042 SD ea=0x18 wdata=0xDEADBEEF_CAFEF00D -> direct WRITE, resp 2 cycles after accept; resp_ready held low 5 cycles -> resp_valid stays high, req_ready stays 0.
REQ-043 rst_n pulsed low during WRITE -> mem_counter 0 immediately, target dword unchanged, no resp_valid.
